// File: rtl/bin2bcd_seq_pkg.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   state_t  - FSM state encoding (IDLE / SHIFT / DONE, 2 bits)
//   clog2()  - constant function used to size the shift counter
// ---------------------------------------------------------------------------
package bin2bcd_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Ceiling log2, never less than 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// ---------------------------------------------------------------------------
// bcd_digit_adj
// Combinational "add 3 if >= 5" correction for one BCD digit, applied before
// each left shift of the double-dabble algorithm.
// Ports:
//   din   in  4  BCD digit before correction
//   dout  out 4  corrected digit
// ---------------------------------------------------------------------------
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Multi-cycle binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with valid/ready handshakes on input and output. Optional two's-complement
// mode converts the magnitude and reports the sign separately.
// Parameters:
//   BIN_W   input binary width (>= 2)
//   DIGITS  number of BCD digits produced
//   SIGNED  1: in_bin is two's complement
// Ports:
//   clk        in   1         rising-edge clock
//   reset      in   1         asynchronous active-high reset
//   in_valid   in   1         in_bin is valid
//   in_ready   out  1         converter idle, can accept
//   in_bin     in   BIN_W     value to convert
//   out_valid  out  1         bcd/sign/ovf valid, held until out_ready
//   out_ready  in   1         consumer takes the result
//   bcd        out  4*DIGITS  packed BCD, digit 0 in bits [3:0]
//   sign       out  1         1 = negative (always 0 when SIGNED=0)
//   ovf        out  1         value did not fit in DIGITS digits
// ---------------------------------------------------------------------------
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 4,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  sign,
    output logic                  ovf
);

    localparam int                BCD_W      = 4 * DIGITS;
    localparam int                CNT_W      = clog2(BIN_W);
    localparam logic [CNT_W-1:0]  LAST_COUNT = CNT_W'(BIN_W - 1);

    state_t              state;
    logic [CNT_W-1:0]    count;
    logic [BIN_W-1:0]    sh;
    logic [BCD_W-1:0]    acc;
    logic                ovf_acc;
    logic                sign_acc;

    logic [BCD_W-1:0]    adj;
    logic [BCD_W-1:0]    next_acc;
    logic [BIN_W-1:0]    next_sh;
    logic                next_ovf;
    logic                negative;
    logic [BIN_W-1:0]    magnitude;

    // Every digit of the accumulator is corrected in parallel before the shift.
    for (genvar g = 0; g < DIGITS; g++) begin : gen_digit
        bcd_digit_adj u_adj (
            .din  (acc[4*g +: 4]),
            .dout (adj[4*g +: 4])
        );
    end

    // Negation in BIN_W bits maps -2^(BIN_W-1) onto its own bit pattern, which
    // read as unsigned is exactly 2^(BIN_W-1). A negative input can never have
    // zero magnitude, so no negative-zero case exists.
    assign negative  = (SIGNED != 0) && in_bin[BIN_W-1];
    assign magnitude = negative ? -in_bin : in_bin;

    // One shift step: the MSB of the binary register enters the accumulator,
    // and whatever leaves the top of the accumulator means the value overflowed.
    assign next_acc = {adj[BCD_W-2:0], sh[BIN_W-1]};
    assign next_sh  = {sh[BIN_W-2:0], 1'b0};
    assign next_ovf = ovf_acc | adj[BCD_W-1];

    assign in_ready = (state == ST_IDLE);

    // FSM with the datapath registers. Result outputs are loaded only when the
    // last shift completes, so they stay stable while a new value is converted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            count     <= '0;
            sh        <= '0;
            acc       <= '0;
            ovf_acc   <= 1'b0;
            sign_acc  <= 1'b0;
            out_valid <= 1'b0;
            bcd       <= '0;
            sign      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        sh       <= magnitude;
                        acc      <= '0;
                        ovf_acc  <= 1'b0;
                        sign_acc <= negative;
                        count    <= '0;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    acc     <= next_acc;
                    sh      <= next_sh;
                    ovf_acc <= next_ovf;
                    count   <= count + CNT_W'(1);
                    if (count == LAST_COUNT) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        bcd       <= next_acc;
                        ovf       <= next_ovf;
                        sign      <= sign_acc;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
